// File: rtl/pulse_stretch_if.sv
// ============================================================================
// pulse_stretch_if : event strobe, configuration and status bundle for pulse_stretch
// Rev 1.0
// ============================================================================
`default_nettype none

interface pulse_stretch_if #(
  parameter int CNT_WIDTH  = 8,
  parameter int PEND_WIDTH = 4
);
  logic                  pulse_in;
  logic [CNT_WIDTH-1:0]  stretch_len;
  logic                  retrig_en;
  logic                  clr_ovf;
  logic                  lvl_out;
  logic                  toggle_out;
  logic                  busy;
  logic [PEND_WIDTH-1:0] pend_cnt;
  logic                  ovf;

  modport master (
    output pulse_in, stretch_len, retrig_en, clr_ovf,
    input  lvl_out, toggle_out, busy, pend_cnt, ovf
  );

  modport slave (
    input  pulse_in, stretch_len, retrig_en, clr_ovf,
    output lvl_out, toggle_out, busy, pend_cnt, ovf
  );
endinterface

`default_nettype wire

// File: rtl/pulse_stretch.sv
// ============================================================================
// pulse_stretch : turns single-cycle events into levels of programmable length
//                 with a guaranteed low gap, plus a toggle output for CDC.
// Rev 1.0
// ============================================================================
`default_nettype none

module pulse_stretch #(
  parameter int CNT_WIDTH  = 8,
  parameter int PEND_WIDTH = 4,
  parameter int MIN_GAP    = 2
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  pulse_stretch_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [3:0]            GAP_INIT = 4'(MIN_GAP);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = {PEND_WIDTH{1'b1}};

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [3:0]            gap_q, gap_d;
  logic [PEND_WIDTH-1:0] pend_q, pend_d;
  logic                  ovf_q, ovf_d;
  logic                  lvl_q, tog_q;
  logic [CNT_WIDTH-1:0]  load_len;
  logic                  inc, dec, check, ovf_set;

  always_comb begin
    load_len = (bus.stretch_len == '0) ? CNT_WIDTH'(1) : bus.stretch_len;
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    inc      = 1'b0;
    dec      = 1'b0;
    check    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.pulse_in) begin
          state_d = HIGH;
          cnt_d   = load_len;
        end
      end
      HIGH: begin
        if (bus.pulse_in && bus.retrig_en) begin
          cnt_d = load_len;
        end else begin
          inc = bus.pulse_in;
          if (cnt_q <= CNT_WIDTH'(1)) begin
            if (MIN_GAP > 0) begin
              state_d = GAP;
              gap_d   = GAP_INIT;
            end else begin
              check = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      GAP: begin
        inc = bus.pulse_in;
        if (gap_q <= 4'd1) begin
          check = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // With an empty queue a pulse on the check cycle starts the next level
    // itself, so it must not also be queued.
    if (check) begin
      if (pend_q != '0) begin
        state_d = HIGH;
        cnt_d   = load_len;
        dec     = 1'b1;
      end else if (bus.pulse_in) begin
        state_d = HIGH;
        cnt_d   = load_len;
        inc     = 1'b0;
      end else begin
        state_d = IDLE;
      end
    end

    pend_d  = pend_q;
    ovf_set = 1'b0;
    if (inc && !dec) begin
      if (pend_q == PEND_MAX) begin
        ovf_set = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (dec && !inc) begin
      pend_d = pend_q - 1'b1;
    end
    ovf_d = ovf_set | (ovf_q & ~bus.clr_ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      lvl_q   <= 1'b0;
      tog_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      lvl_q   <= (state_d == HIGH);
      tog_q   <= tog_q ^ bus.pulse_in;
    end
  end

  assign bus.lvl_out    = lvl_q;
  assign bus.toggle_out = tog_q;
  assign bus.pend_cnt   = pend_q;
  assign bus.ovf        = ovf_q;
  assign bus.busy       = (state_q != IDLE) || (pend_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_pulse_stretch.sv
// ============================================================================
// tb_pulse_stretch : directed bench for pulse_stretch (MIN_GAP=2 and MIN_GAP=0 builds)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pulse_stretch;
  localparam int CW = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pulse_in = 1'b0;
  logic [CW-1:0] stretch_len = '0;
  logic          retrig_en = 1'b0;
  logic          clr_ovf = 1'b0;
  bit            chk_en = 1'b0;
  int            n_total = 0;
  int            n_pass = 0;
  logic [31:0]   lv0, bz0, lv1;
  int            pmax;

  always #5 clk = ~clk;

  pulse_stretch_if #(.CNT_WIDTH(CW), .PEND_WIDTH(PW)) bus0 ();
  pulse_stretch_if #(.CNT_WIDTH(CW), .PEND_WIDTH(PW)) bus1 ();

  assign bus0.pulse_in    = pulse_in;
  assign bus0.stretch_len = stretch_len;
  assign bus0.retrig_en   = retrig_en;
  assign bus0.clr_ovf     = clr_ovf;
  assign bus1.pulse_in    = pulse_in;
  assign bus1.stretch_len = stretch_len;
  assign bus1.retrig_en   = retrig_en;
  assign bus1.clr_ovf     = clr_ovf;

  pulse_stretch #(.CNT_WIDTH(CW), .PEND_WIDTH(PW), .MIN_GAP(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  pulse_stretch #(.CNT_WIDTH(CW), .PEND_WIDTH(PW), .MIN_GAP(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  // Model: remaining high cycles, remaining gap cycles and a queue depth.
  typedef struct {
    int hi;
    int gap;
    int pend;
    bit ovf;
    bit tog;
  } mdl_t;

  mdl_t m [2];

  function automatic mdl_t step(mdl_t s, int min_gap, bit p, int len, bit rt, bit clr);
    mdl_t n    = s;
    bit   inc  = 1'b0;
    bit   dec  = 1'b0;
    bit   chk  = 1'b0;
    bit   oset = 1'b0;
    int   l    = (len == 0) ? 1 : len;
    int   maxp = (1 << PW) - 1;
    if (s.hi > 0) begin
      if (p && rt) begin
        n.hi = l;
      end else begin
        inc = p;
        if (s.hi == 1) begin
          n.hi = 0;
          if (min_gap > 0) n.gap = min_gap;
          else chk = 1'b1;
        end else begin
          n.hi = s.hi - 1;
        end
      end
    end else if (s.gap > 0) begin
      inc   = p;
      n.gap = s.gap - 1;
      if (s.gap == 1) chk = 1'b1;
    end else if (p) begin
      n.hi = l;
    end
    if (chk) begin
      if (s.pend > 0) begin
        n.hi = l;
        dec  = 1'b1;
      end else if (p) begin
        n.hi = l;
        inc  = 1'b0;
      end
    end
    if (inc && !dec) begin
      if (s.pend == maxp) oset = 1'b1;
      else n.pend = s.pend + 1;
    end else if (dec && !inc) begin
      n.pend = s.pend - 1;
    end
    n.ovf = oset | (s.ovf & ~clr);
    n.tog = s.tog ^ p;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= '{default: 0};
      m[1] <= '{default: 0};
    end else begin
      m[0] <= step(m[0], 2, pulse_in, int'(stretch_len), retrig_en, clr_ovf);
      m[1] <= step(m[1], 0, pulse_in, int'(stretch_len), retrig_en, clr_ovf);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m0_lvl",  int'(bus0.lvl_out),    int'(m[0].hi > 0));
      check("m0_tog",  int'(bus0.toggle_out), int'(m[0].tog));
      check("m0_busy", int'(bus0.busy),       int'(m[0].hi > 0 || m[0].gap > 0 || m[0].pend > 0));
      check("m0_pend", int'(bus0.pend_cnt),   m[0].pend);
      check("m0_ovf",  int'(bus0.ovf),        int'(m[0].ovf));
      check("m1_lvl",  int'(bus1.lvl_out),    int'(m[1].hi > 0));
      check("m1_tog",  int'(bus1.toggle_out), int'(m[1].tog));
      check("m1_busy", int'(bus1.busy),       int'(m[1].hi > 0 || m[1].gap > 0 || m[1].pend > 0));
      check("m1_pend", int'(bus1.pend_cnt),   m[1].pend);
      check("m1_ovf",  int'(bus1.ovf),        int'(m[1].ovf));
    end
  end

  // Bit i of each trace holds the output sampled just after edge i.
  task automatic run(input int n, input logic [31:0] pmask);
    lv0  = '0;
    bz0  = '0;
    lv1  = '0;
    pmax = 0;
    for (int i = 0; i < n; i++) begin
      pulse_in = pmask[i];
      @(posedge clk);
      #1;
      pulse_in = 1'b0;
      lv0[i]   = bus0.lvl_out;
      bz0[i]   = bus0.busy;
      lv1[i]   = bus1.lvl_out;
      if (int'(bus0.pend_cnt) > pmax) pmax = int'(bus0.pend_cnt);
    end
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    check("rst_lvl",  int'(bus0.lvl_out), 0);
    check("rst_tog",  int'(bus0.toggle_out), 0);
    check("rst_busy", int'(bus0.busy), 0);
    check("rst_pend", int'(bus0.pend_cnt), 0);
    check("rst_ovf",  int'(bus0.ovf), 0);

    stretch_len = 8'd4; retrig_en = 1'b0;
    run(8, 32'h1);
    check("t1_lvl",  int'(lv0[7:0]), 8'h0F);
    check("t1_busy", int'(bz0[7:0]), 8'h3F);
    check("t1_tog",  int'(bus0.toggle_out), 1);

    stretch_len = 8'd0;
    run(4, 32'h1);
    check("len0_lvl", int'(lv0[3:0]), 4'b0001);
    stretch_len = 8'd5; retrig_en = 1'b1;
    run(12, 32'b1001);
    check("retrig_lvl", int'(lv0[11:0]), 12'h0FF);
    check("retrig_tog", int'(bus0.toggle_out), 0);

    stretch_len = 8'd3; retrig_en = 1'b0;
    run(16, 32'b111);
    check("queue_lvl",  int'(lv0[15:0]), 16'h1CE7);
    check("queue_pmax", pmax, 2);
    check("queue_idle", int'(bz0[15]), 0);

    stretch_len = 8'd2;
    run(6, 32'b11);
    check("gap0_lvl", int'(lv1[5:0]), 6'b001111);
    check("gap2_lvl", int'(lv0[5:0]), 6'b110011);
    run(10, 32'h0);

    stretch_len = 8'd200;
    run(20, 32'h000F_FFFF);
    check("sat_pend", int'(bus0.pend_cnt), 15);
    check("sat_ovf",  int'(bus0.ovf), 1);
    clr_ovf = 1'b1;
    run(1, 32'h1);
    clr_ovf = 1'b0;
    check("ovf_set_wins", int'(bus0.ovf), 1);
    clr_ovf = 1'b1;
    run(1, 32'h0);
    clr_ovf = 1'b0;
    check("ovf_clr", int'(bus0.ovf), 0);

    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    stretch_len = 8'd10;
    run(4, 32'hF);
    retrig_en = 1'b1;
    run(1, 32'h1);
    retrig_en = 1'b0;
    check("pre_rst_pend", int'(bus0.pend_cnt), 3);
    check("pre_rst_lvl",  int'(bus0.lvl_out), 1);
    check("pre_rst_tog",  int'(bus0.toggle_out), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_lvl",  int'(bus0.lvl_out), 0);
    check("arst_pend", int'(bus0.pend_cnt), 0);
    check("arst_tog",  int'(bus0.toggle_out), 0);
    check("arst_busy", int'(bus0.busy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(6, 32'h0);
    check("post_rst_lvl",  int'(lv0[5:0]), 0);
    check("post_rst_busy", int'(bz0[5:0]), 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/pulse_stretch.md
Name: pulse_stretch

Overview:
- Inverse of the level-to-pulse generator: converts single-cycle pulses into a clean high level of programmable length.
- Guarantees a minimum low gap between consecutive levels, so a slower or downstream domain can detect every event.
- Also provides a toggle output for toggle-based CDC, plus pending-event queueing or retriggering.
- Sits on the transmit side of a crossing, ahead of the synchroniser and the level-to-pulse generator on the far side.

Parameters:
- CNT_WIDTH, 8: width of STRETCH_LEN and the internal length counter.
- PEND_WIDTH, 4: width of the pending-pulse counter; saturates at 2^PEND_WIDTH-1.
- MIN_GAP, 2: forced low cycles after each level. Allowed range 0..15.

Ports:
- CLK  input  1  clock.
- RST  input  1  asynchronous active-low reset.
- PULSE_IN  input  1  event strobe; every cycle it is high counts as one event.
- STRETCH_LEN  input  CNT_WIDTH  level length in cycles; 0 is treated as 1.
- RETRIG_EN  input  1  1: a pulse during the level extends it; 0: a pulse during the level is queued.
- CLR_OVF  input  1  clears the OVF flag.
- LVL_OUT  output  1  stretched level, registered.
- TOGGLE_OUT  output  1  flips on every PULSE_IN, registered.
- BUSY  output  1  high when state!=IDLE or PEND_CNT!=0.
- PEND_CNT  output  PEND_WIDTH  number of queued events.
- OVF  output  1  sticky flag: a pulse was lost because PEND_CNT was saturated.

Behaviour:
- Reset values: state=IDLE, LVL_OUT=0, TOGGLE_OUT=0, PEND_CNT=0, OVF=0, counters 0. Reset asserted mid-level drops LVL_OUT immediately and discards the queue.
- Load length L = (STRETCH_LEN==0) ? 1 : STRETCH_LEN, sampled only at load edges. Changes to STRETCH_LEN mid-level have no effect.
- All outputs are registered. LVL_OUT rises on the edge that samples the triggering PULSE_IN (1-cycle latency, same as the pulse generator).
- State IDLE:
  - PULSE_IN=1 -> HIGH, counter=L.
- State HIGH:
  - LVL_OUT=1, counter decrements each cycle.
  - A level with no retrigger lasts exactly L cycles.
  - PULSE_IN=1 with RETRIG_EN=1 -> counter reloads to L, so the level stays high for L cycles after that edge. This includes a pulse in the last high cycle (no low glitch).
  - PULSE_IN=1 with RETRIG_EN=0 -> PEND_CNT+1.
  - Last cycle, no retrigger: if MIN_GAP>0 -> GAP with gap counter=MIN_GAP. If MIN_GAP=0 -> pending-check, below.
- State GAP:
  - LVL_OUT=0 for exactly MIN_GAP cycles.
  - PULSE_IN=1 -> PEND_CNT+1, regardless of RETRIG_EN.
  - At gap end -> pending-check.
- Pending-check:
  - PEND_CNT>0 -> HIGH, reload L, PEND_CNT-1.
  - Otherwise -> IDLE, unless PULSE_IN=1 on that same cycle, in which case -> HIGH directly.
  - With MIN_GAP=0, queued levels therefore merge into one continuous high.
- Simultaneous increment and decrement of PEND_CNT: net unchanged, no OVF.
- Saturation: an increment while PEND_CNT is at max leaves PEND_CNT at max and sets OVF.
- OVF is sticky until CLR_OVF=1. If set and clear occur on the same cycle, set wins.
- TOGGLE_OUT inverts on every cycle PULSE_IN=1, independent of state, queueing or saturation.
- BUSY is combinational from registered state and PEND_CNT only; it has no path from PULSE_IN.

Test Plan:
- Reset 5 cycles, then one pulse with STRETCH_LEN=4, RETRIG_EN=0 -> LVL_OUT high exactly cycles 1..4 after the pulse edge, low 2 cycles, BUSY falls with the return to IDLE, TOGGLE_OUT=1.
- STRETCH_LEN=0, single pulse -> LVL_OUT high 1 cycle. Then STRETCH_LEN=5 with RETRIG_EN=1 and pulses at t=0 and t=3 -> LVL_OUT high for 8 contiguous cycles, TOGGLE_OUT back to 0.
- RETRIG_EN=0, STRETCH_LEN=3, pulses at t=0,1,2 -> three 3-cycle levels, each separated by 2 low cycles. PEND_CNT peaks at 2 and decrements at each reload.
- PEND_WIDTH=4, STRETCH_LEN=200, 20 back-to-back pulses -> PEND_CNT saturates at 15, OVF=1. CLR_OVF pulsed together with a further pulse -> OVF stays 1. CLR_OVF alone -> OVF=0.
- RST asserted mid-level with PEND_CNT=3 -> LVL_OUT, PEND_CNT and TOGGLE_OUT go to 0 asynchronously. After release there is no level until a new pulse arrives.
- MIN_GAP=0 build, STRETCH_LEN=2, pulses at t=0,1 with RETRIG_EN=0 -> LVL_OUT continuously high 4 cycles, no low gap.
